// File: rtl/cpu_multicycle_pkg.sv
// cpu_multicycle_pkg: shared opcode/funct constants, FSM state type and
// decode helpers for the multi-cycle core.
// Optional feature: define CPU_MULTICYCLE_SHIFT_EN to enable SHL/SHR.
package cpu_multicycle_pkg;

    localparam logic [3:0] OP_ALU  = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0100;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [3:0] FN_ADD = 4'b1010;
    localparam logic [3:0] FN_SUB = 4'b0010;
    localparam logic [3:0] FN_AND = 4'b1100;
    localparam logic [3:0] FN_OR  = 4'b1110;
    localparam logic [3:0] FN_XOR = 4'b1101;
    localparam logic [3:0] FN_NOT = 4'b1011;
    localparam logic [3:0] FN_SHL = 4'b0100;
    localparam logic [3:0] FN_SHR = 4'b0101;

`ifdef CPU_MULTICYCLE_SHIFT_EN
    localparam bit SHIFT_EN = 1'b1;
`else
    localparam bit SHIFT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        WB    = 2'd2,
        HALT  = 2'd3
    } state_t;

    // True when an ALU-opcode funct produces a register write.
    function automatic logic funct_writes(input logic [3:0] funct);
        logic w;
        case (funct)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NOT: w = 1'b1;
            FN_SHL, FN_SHR:                                w = SHIFT_EN;
            default:                                       w = 1'b0;
        endcase
        return w;
    endfunction

    // True when an ALU-opcode funct updates the carry flag.
    function automatic logic funct_sets_carry(input logic [3:0] funct);
        logic c;
        case (funct)
            FN_ADD, FN_SUB: c = 1'b1;
            FN_SHL, FN_SHR: c = SHIFT_EN;
            default:        c = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cpu_multicycle_alu.sv
// cpu_multicycle_alu: purely combinational W-bit ALU selected by funct.
// SHL/SHR are only decoded when CPU_MULTICYCLE_SHIFT_EN is defined.
module cpu_multicycle_alu #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [3:0]   funct,
    output logic [W-1:0] result,
    output logic         carry_out
);
    import cpu_multicycle_pkg::*;

    logic [W:0] sum;

    // Result and carry-out for the selected operation; unknown functs give 0.
    always_comb begin
        sum       = '0;
        result    = '0;
        carry_out = 1'b0;
        case (funct)
            FN_ADD: begin
                sum       = {1'b0, a} + {1'b0, b};
                result    = sum[W-1:0];
                carry_out = sum[W];
            end
            FN_SUB: begin
                sum       = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
                result    = sum[W-1:0];
                carry_out = sum[W];
            end
            FN_AND: result = a & b;
            FN_OR:  result = a | b;
            FN_XOR: result = a ^ b;
            FN_NOT: result = ~a;
            FN_SHL: begin
                if (SHIFT_EN) begin
                    result    = {a[W-2:0], 1'b0};
                    carry_out = a[W-1];
                end
            end
            FN_SHR: begin
                if (SHIFT_EN) begin
                    result    = {1'b0, a[W-1:1]};
                    carry_out = a[0];
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_multicycle.sv
// cpu_multicycle: top-level multi-cycle core with handshaked instruction
// fetch, FETCH/EXEC/WB/HALT state machine, 16 x W register file and PC.
// Optional feature: CPU_MULTICYCLE_SHIFT_EN enables SHL/SHR functs.
module cpu_multicycle #(
    parameter int W = 16
) (
    input  logic         CK,
    input  logic         RST,
    output logic         imem_req,
    output logic [W-1:0] imem_addr,
    input  logic [15:0]  imem_rdata,
    input  logic         imem_ack,
    output logic [W-1:0] R,
    output logic [W-1:0] pc,
    output logic         carry,
    output logic         halted
);
    import cpu_multicycle_pkg::*;

    state_t       state_q, state_d;
    logic [W-1:0] pc_q, pc_d;
    logic [15:0]  ir_q, ir_d;
    logic [W-1:0] res_q, res_d;
    logic         res_c_q, res_c_d;
    logic         res_we_q, res_we_d;
    logic         res_cu_q, res_cu_d;
    logic [W-1:0] r_q, r_d;
    logic         carry_q, carry_d;
    logic [W-1:0] regs_q [16];
    logic [W-1:0] regs_d [16];

    logic [3:0]   opcode, rd, rs, funct;
    logic [W-1:0] imm_sext;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic [3:0]   alu_funct;
    logic         alu_carry;

    assign opcode   = ir_q[15:12];
    assign rd       = ir_q[11:8];
    assign funct    = ir_q[7:4];
    assign rs       = ir_q[3:0];
    assign imm_sext = {{(W-8){ir_q[7]}}, ir_q[7:0]};

    // ADDI reuses the ALU adder with the sign-extended immediate as operand B.
    assign alu_a     = regs_q[rd];
    assign alu_b     = (opcode == OP_ADDI) ? imm_sext : regs_q[rs];
    assign alu_funct = (opcode == OP_ADDI) ? FN_ADD : funct;

    cpu_multicycle_alu #(
        .W(W)
    ) u_alu (
        .a        (alu_a),
        .b        (alu_b),
        .funct    (alu_funct),
        .result   (alu_result),
        .carry_out(alu_carry)
    );

    // State register; reset returns to FETCH.
    always_ff @(posedge CK) begin
        if (RST) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers; reset restores PC, flags and the register file.
    always_ff @(posedge CK) begin
        if (RST) begin
            pc_q     <= '0;
            ir_q     <= '0;
            res_q    <= '0;
            res_c_q  <= 1'b0;
            res_we_q <= 1'b0;
            res_cu_q <= 1'b0;
            r_q      <= '0;
            carry_q  <= 1'b0;
            for (int unsigned i = 0; i < 16; i++) begin
                regs_q[i] <= W'(i);
            end
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            res_q    <= res_d;
            res_c_q  <= res_c_d;
            res_we_q <= res_we_d;
            res_cu_q <= res_cu_d;
            r_q      <= r_d;
            carry_q  <= carry_d;
            regs_q   <= regs_d;
        end
    end

    // Next-state and datapath updates for fetch, execute and write-back.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        res_d    = res_q;
        res_c_d  = res_c_q;
        res_we_d = res_we_q;
        res_cu_d = res_cu_q;
        r_d      = r_q;
        carry_d  = carry_q;
        regs_d   = regs_q;
        case (state_q)
            FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    pc_d    = pc_q + W'(2);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (opcode == OP_HALT) begin
                    state_d = HALT;
                end else begin
                    res_d    = alu_result;
                    res_c_d  = alu_carry;
                    res_we_d = (opcode == OP_ADDI) ||
                               ((opcode == OP_ALU) && funct_writes(funct));
                    res_cu_d = (opcode == OP_ADDI) ||
                               ((opcode == OP_ALU) && funct_sets_carry(funct));
                    state_d  = WB;
                end
            end
            WB: begin
                if (res_we_q) begin
                    regs_d[rd] = res_q;
                    r_d        = res_q;
                    if (res_cu_q) begin
                        carry_d = res_c_q;
                    end
                end
                state_d = FETCH;
            end
            HALT: state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    assign imem_req  = (state_q == FETCH);
    assign imem_addr = pc_q;
    assign R         = r_q;
    assign pc        = pc_q;
    assign carry     = carry_q;
    assign halted    = (state_q == HALT);

endmodule

// File: tb/tb_cpu_multicycle.sv
// tb_cpu_multicycle: table-driven program vectors with a scoreboard queue.
// Each accepted fetch pushes an entry due three cycles later; the entry is
// compared against hand-computed R/carry/pc/halted values.
module tb_cpu_multicycle;

    localparam int W = 16;

    logic         CK = 1'b0;
    logic         RST = 1'b1;
    logic         imem_req;
    logic [W-1:0] imem_addr;
    logic [15:0]  imem_rdata = '0;
    logic         imem_ack = 1'b0;
    logic [W-1:0] R;
    logic [W-1:0] pc;
    logic         carry;
    logic         halted;

    cpu_multicycle #(.W(W)) dut (
        .CK        (CK),
        .RST       (RST),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_rdata(imem_rdata),
        .imem_ack  (imem_ack),
        .R         (R),
        .pc        (pc),
        .carry     (carry),
        .halted    (halted)
    );

    always #5 CK = ~CK;

    typedef struct {
        logic [15:0]  instr;
        logic [W-1:0] exp_r;
        logic         exp_c;
        bit           is_halt;
    } vec_t;

    typedef struct {
        int due;
        int idx;
    } sb_t;

    vec_t         prog [32];
    sb_t          q [$];
    int           n_vec = 0;
    int           n_err = 0;
    int           cyc = 0;
    int           stall_left = 0;
    int           fetch_cnt = 0;
    logic [W-1:0] next_addr = '0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 32; i++) begin
            prog[i] = '{instr: 16'h0000, exp_r: '0, exp_c: 1'b0, is_halt: 1'b0};
        end
    endtask

    task automatic set_vec(input int i, input logic [15:0] ins, input logic [W-1:0] r,
                           input logic c, input bit h);
        prog[i] = '{instr: ins, exp_r: r, exp_c: c, is_halt: h};
    endtask

    // Holds reset two cycles, checks reset state, then releases it.
    task automatic do_reset();
        RST = 1'b1;
        repeat (2) @(posedge CK);
        #2;
        next_addr = '0;
        fetch_cnt = 0;
        chk("rst_pc", pc, '0);
        chk("rst_R", R, '0);
        chk("rst_carry", W'(carry), '0);
        chk("rst_halted", W'(halted), '0);
        chk("rst_req", W'(imem_req), W'(1));
        RST = 1'b0;
    endtask

    task automatic wait_halt(input int budget);
        int i;
        i = 0;
        while (i < budget && !(halted === 1'b1 && q.size() == 0)) begin
            @(posedge CK);
            #2;
            i++;
        end
        chk("halt_within_budget", W'(halted === 1'b1 && q.size() == 0), W'(1));
    endtask

    // Memory responder and scoreboard checker, both on the falling edge.
    initial begin
        sb_t e;
        forever begin
            @(negedge CK);
            cyc++;
            while (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                chk($sformatf("v%0d_due", e.idx), W'(e.due), W'(cyc));
                chk($sformatf("v%0d_R", e.idx), R, prog[e.idx].exp_r);
                chk($sformatf("v%0d_carry", e.idx), W'(carry), W'(prog[e.idx].exp_c));
                chk($sformatf("v%0d_pc", e.idx), pc, W'((e.idx + 1) * 2));
                chk($sformatf("v%0d_halted", e.idx), W'(halted), W'(prog[e.idx].is_halt));
                if (prog[e.idx].is_halt) begin
                    chk($sformatf("v%0d_req_low", e.idx), W'(imem_req), '0);
                end
            end
            if (RST) begin
                imem_ack   = (imem_req === 1'b1);
                imem_rdata = prog[next_addr[5:1]].instr;
            end else if (imem_req === 1'b1) begin
                chk("fetch_addr", imem_addr, next_addr);
                if (stall_left > 0) begin
                    imem_ack = 1'b0;
                    stall_left--;
                end else begin
                    imem_ack   = 1'b1;
                    imem_rdata = prog[next_addr[5:1]].instr;
                    q.push_back('{due: cyc + 3, idx: int'(next_addr[5:1])});
                    next_addr  = next_addr + W'(2);
                    fetch_cnt++;
                end
            end else begin
                imem_ack = 1'b0;
            end
        end
    end

    initial begin
        int i;
        // Main program: register file starts as reg[i] = i.
        clear_prog();
        set_vec(0,  16'h01AA, 16'h000B, 1'b0, 0); // ADD r1,r10
        set_vec(1,  16'h0223, 16'hFFFF, 1'b0, 0); // SUB r2,r3
        set_vec(2,  16'h0424, 16'h0000, 1'b1, 0); // SUB r4,r4
        set_vec(3,  16'h45FF, 16'h0004, 1'b1, 0); // ADDI r5,#-1
        set_vec(4,  16'h407F, 16'h007F, 1'b0, 0); // ADDI r0,#0x7F
        set_vec(5,  16'h2123, 16'h007F, 1'b0, 0); // illegal opcode
        set_vec(6,  16'h01C2, 16'h000B, 1'b0, 0); // AND r1,r2
        set_vec(7,  16'h06E7, 16'h0007, 1'b0, 0); // OR r6,r7
        set_vec(8,  16'h01D0, 16'h0074, 1'b0, 0); // XOR r1,r0
        set_vec(9,  16'h09B0, 16'hFFF6, 1'b0, 0); // NOT r9
        set_vec(10, 16'h09A9, 16'hFFEC, 1'b1, 0); // ADD r9,r9
        set_vec(11, 16'h0100, 16'hFFEC, 1'b1, 0); // unlisted funct
        set_vec(12, 16'h03C3, 16'h0003, 1'b1, 0); // AND r3,r3 keeps carry
        set_vec(13, 16'h01A2, 16'h0073, 1'b1, 0); // ADD r1,r2
`ifdef CPU_MULTICYCLE_SHIFT_EN
        set_vec(14, 16'h0940, 16'hFFD8, 1'b1, 0); // SHL r9
        set_vec(15, 16'h0950, 16'h7FEC, 1'b0, 0); // SHR r9
        set_vec(16, 16'hF000, 16'h7FEC, 1'b0, 1); // HALT
`else
        set_vec(14, 16'h0940, 16'h0073, 1'b1, 0); // funct 0100 is a NOP
        set_vec(15, 16'h0950, 16'h0073, 1'b1, 0); // funct 0101 is a NOP
        set_vec(16, 16'hF000, 16'h0073, 1'b1, 1); // HALT
`endif
        do_reset();
        wait_halt(300);

        // Four wait cycles on the first fetch.
        clear_prog();
        set_vec(0, 16'h01AA, 16'h000B, 1'b0, 0);
        set_vec(1, 16'hF000, 16'h000B, 1'b0, 1);
        stall_left = 4;
        do_reset();
        wait_halt(100);
        chk("stall_consumed", W'(stall_left), '0);

        // HALT stops fetching; the following ADD is never fetched.
        clear_prog();
        set_vec(0, 16'h01AA, 16'h000B, 1'b0, 0);
        set_vec(1, 16'hF000, 16'h000B, 1'b0, 1);
        set_vec(2, 16'h01AA, 16'h0015, 1'b0, 0);
        do_reset();
        wait_halt(100);
        repeat (10) @(posedge CK);
        #2;
        chk("halt_fetch_cnt", W'(fetch_cnt), W'(2));
        chk("halt_pc", pc, W'(4));
        chk("halt_req", W'(imem_req), '0);
        chk("halt_stays", W'(halted), W'(1));

        // Reset out of HALT restores r1 = 1 (ADD r1,r0 with r0 = 0).
        clear_prog();
        set_vec(0, 16'h01A0, 16'h0001, 1'b0, 0);
        set_vec(1, 16'hF000, 16'h0001, 1'b0, 1);
        do_reset();
        wait_halt(100);

        // Reset asserted mid-fetch with ack high takes priority.
        clear_prog();
        set_vec(0, 16'h45FF, 16'h0004, 1'b1, 0);
        set_vec(1, 16'h45FF, 16'h0003, 1'b1, 0);
        set_vec(2, 16'hF000, 16'h0003, 1'b1, 1);
        do_reset();
        i = 0;
        while (i < 50 && !(fetch_cnt == 1 && imem_req === 1'b1)) begin
            @(posedge CK);
            #2;
            i++;
        end
        chk("midfetch_reached", W'(fetch_cnt == 1 && imem_req === 1'b1), W'(1));
        RST = 1'b1;
        repeat (2) @(posedge CK);
        #2;
        chk("midrst_R", R, '0);
        chk("midrst_carry", W'(carry), '0);
        chk("midrst_pc", pc, '0);
        next_addr = '0;
        fetch_cnt = 0;
        RST = 1'b0;
        wait_halt(100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
